// File: rtl/icache_pkg.sv
// Shared types, geometry defaults and FSM encoding for the direct-mapped instruction cache.
package icache_pkg;

    localparam int ADDR_W                = 32;
    localparam int WORD_W                = 32;
    localparam int ICACHE_INDEX_BITS     = 6;
    localparam int ICACHE_LINE_WORDS_LOG = 2;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic {
        ICACHE_IDLE   = 1'b0,
        ICACHE_REFILL = 1'b1
    } state_e;

    // Clears the byte-offset-within-line bits of an address.
    function automatic addr_t line_base(addr_t a, int unsigned off_bits);
        return a & ~((addr_t'(1) << off_bits) - addr_t'(1));
    endfunction

endpackage

// File: rtl/icache_if.sv
// Fetch-side lookup port (fetcher is master) and refill port (cache is master).
interface icache_fetch_if;
    import icache_pkg::*;

    logic  cache_rd_en;
    addr_t cache_rd_addr;
    logic  cache_hit;
    word_t cache_hit_inst;

    modport master (output cache_rd_en, cache_rd_addr, input cache_hit, cache_hit_inst);
    modport slave  (input cache_rd_en, cache_rd_addr, output cache_hit, cache_hit_inst);
endinterface

interface icache_mem_if;
    import icache_pkg::*;

    logic  mem_rd_en;
    addr_t mem_rd_addr;
    logic  mem_rd_done;
    word_t mem_rd_data;

    modport master (output mem_rd_en, mem_rd_addr, input mem_rd_done, mem_rd_data);
    modport slave  (input mem_rd_en, mem_rd_addr, output mem_rd_done, mem_rd_data);
endinterface

// File: rtl/icache_refill_fsm.sv
// Line refill sequencer: issues word requests for one line and strobes each returned word.
module icache_refill_fsm
    import icache_pkg::*;
#(
    parameter int INDEX_BITS     = ICACHE_INDEX_BITS,
    parameter int LINE_WORDS_LOG = ICACHE_LINE_WORDS_LOG
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      miss_i,
    input  addr_t                     miss_addr_i,
    input  logic                      mem_rd_done_i,
    output logic                      mem_rd_en_o,
    output addr_t                     mem_rd_addr_o,
    output logic                      start_o,
    output logic                      word_we_o,
    output logic                      line_done_o,
    output logic [LINE_WORDS_LOG-1:0] wr_off_o
);

    localparam logic [LINE_WORDS_LOG-1:0] LAST = {LINE_WORDS_LOG{1'b1}};

    state_e                    state_q, state_d;
    logic [LINE_WORDS_LOG-1:0] cnt_q, cnt_d;
    logic                      mem_rd_en_q, mem_rd_en_d;
    addr_t                     mem_rd_addr_q, mem_rd_addr_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ICACHE_IDLE;
            cnt_q         <= '0;
            mem_rd_en_q   <= 1'b0;
            mem_rd_addr_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            mem_rd_en_q   <= mem_rd_en_d;
            mem_rd_addr_q <= mem_rd_addr_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        mem_rd_en_d   = mem_rd_en_q;
        mem_rd_addr_d = mem_rd_addr_q;
        case (state_q)
            ICACHE_IDLE: begin
                if (miss_i) begin
                    state_d       = ICACHE_REFILL;
                    cnt_d         = '0;
                    mem_rd_en_d   = 1'b1;
                    mem_rd_addr_d = line_base(miss_addr_i, LINE_WORDS_LOG + 2);
                end
            end
            ICACHE_REFILL: begin
                if (mem_rd_done_i) begin
                    cnt_d = cnt_q + 1'b1;
                    // The address stays on the last word so it never leaves the line.
                    if (cnt_q == LAST) begin
                        state_d     = ICACHE_IDLE;
                        mem_rd_en_d = 1'b0;
                    end else begin
                        mem_rd_addr_d = mem_rd_addr_q + ADDR_W'(4);
                    end
                end
            end
            default: state_d = ICACHE_IDLE;
        endcase
    end

    always_comb begin
        start_o       = (state_q == ICACHE_IDLE) && miss_i;
        word_we_o     = (state_q == ICACHE_REFILL) && mem_rd_done_i;
        line_done_o   = (state_q == ICACHE_REFILL) && mem_rd_done_i && (cnt_q == LAST);
        wr_off_o      = cnt_q;
        mem_rd_en_o   = mem_rd_en_q;
        mem_rd_addr_o = mem_rd_addr_q;
    end

endmodule

// File: rtl/icache.sv
// Direct-mapped instruction cache with combinational lookup and word-by-word line refill.
module icache
    import icache_pkg::*;
#(
    parameter int INDEX_BITS     = ICACHE_INDEX_BITS,
    parameter int LINE_WORDS_LOG = ICACHE_LINE_WORDS_LOG
) (
    input  logic           clk,
    input  logic           rst,
    icache_fetch_if.slave  fetch,
    icache_mem_if.master   mem
);

    localparam int LINES   = 1 << INDEX_BITS;
    localparam int WORDS   = 1 << LINE_WORDS_LOG;
    localparam int IDX_LSB = LINE_WORDS_LOG + 2;
    localparam int TAG_LSB = IDX_LSB + INDEX_BITS;
    localparam int TAG_W   = ADDR_W - TAG_LSB;

    logic [TAG_W-1:0]          tag_q  [LINES];
    word_t                     data_q [LINES][WORDS];
    logic [LINES-1:0]          valid_vec;

    logic [LINE_WORDS_LOG-1:0] rd_off, wr_off;
    logic [INDEX_BITS-1:0]     rd_idx, wr_idx;
    logic [TAG_W-1:0]          rd_tag, wr_tag;
    logic                      hit, start, word_we, line_done;
    logic [3:0]                unused_addr_bits;

    assign rd_off = fetch.cache_rd_addr[IDX_LSB-1:2];
    assign rd_idx = fetch.cache_rd_addr[TAG_LSB-1:IDX_LSB];
    assign rd_tag = fetch.cache_rd_addr[ADDR_W-1:TAG_LSB];
    assign wr_idx = mem.mem_rd_addr[TAG_LSB-1:IDX_LSB];
    assign wr_tag = mem.mem_rd_addr[ADDR_W-1:TAG_LSB];
    assign unused_addr_bits = {fetch.cache_rd_addr[1:0], mem.mem_rd_addr[1:0]};

    assign hit                  = fetch.cache_rd_en && valid_vec[rd_idx] && (tag_q[rd_idx] == rd_tag);
    assign fetch.cache_hit      = hit;
    assign fetch.cache_hit_inst = fetch.cache_rd_en ? data_q[rd_idx][rd_off] : '0;

    icache_refill_fsm #(
        .INDEX_BITS     (INDEX_BITS),
        .LINE_WORDS_LOG (LINE_WORDS_LOG)
    ) u_refill (
        .clk           (clk),
        .rst           (rst),
        .miss_i        (fetch.cache_rd_en && !hit),
        .miss_addr_i   (fetch.cache_rd_addr),
        .mem_rd_done_i (mem.mem_rd_done),
        .mem_rd_en_o   (mem.mem_rd_en),
        .mem_rd_addr_o (mem.mem_rd_addr),
        .start_o       (start),
        .word_we_o     (word_we),
        .line_done_o   (line_done),
        .wr_off_o      (wr_off)
    );

    // Valid drops when a refill starts so a half-written line can never hit.
    for (genvar gi = 0; gi < LINES; gi++) begin : g_line
        logic valid_q;
        always_ff @(posedge clk) begin
            if (rst) begin
                valid_q <= 1'b0;
            end else if (start && (rd_idx == INDEX_BITS'(gi))) begin
                valid_q <= 1'b0;
            end else if (line_done && (wr_idx == INDEX_BITS'(gi))) begin
                valid_q <= 1'b1;
            end
        end
        assign valid_vec[gi] = valid_q;
    end

    always_ff @(posedge clk) begin
        if (word_we) begin
            data_q[wr_idx][wr_off] <= mem.mem_rd_data;
        end
        if (line_done) begin
            tag_q[wr_idx] <= wr_tag;
        end
    end

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: bench-side memory responder with an address scoreboard.
module tb_icache;
    import icache_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_bad = 0;
    addr_t addr_q [$];

    always #5 clk = ~clk;

    icache_fetch_if f ();
    icache_mem_if   m ();

    icache dut (
        .clk   (clk),
        .rst   (rst),
        .fetch (f.slave),
        .mem   (m.master)
    );

    function automatic word_t mem_word(addr_t a);
        return {a[15:0] ^ 16'hC0DE, a[15:0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %-12s got=%08h exp=%08h t=%0t", tag, got, exp, $time);
        end else begin
            $display("ok   %-12s val=%08h t=%0t", tag, got, $time);
        end
    endtask

    // One-cycle lookup driven at a negedge; rd_en is dropped before the next edge.
    task automatic lookup(input addr_t a, input logic exp_hit, input word_t exp_inst);
        @(negedge clk);
        f.cache_rd_en   = 1'b1;
        f.cache_rd_addr = a;
        #1;
        check("hit", 32'(f.cache_hit), 32'(exp_hit));
        if (exp_hit) check("inst", f.cache_hit_inst, exp_inst);
        f.cache_rd_en = 1'b0;
    endtask

    // Present a missing address across one edge and queue the expected refill addresses.
    task automatic start_miss(input addr_t a);
        addr_t base;
        base = a & 32'hFFFF_FFF0;
        @(negedge clk);
        f.cache_rd_en   = 1'b1;
        f.cache_rd_addr = a;
        #1;
        check("miss_hit", 32'(f.cache_hit), 32'd0);
        for (int k = 0; k < 4; k++) addr_q.push_back(base + 32'(4 * k));
        @(negedge clk);
        f.cache_rd_en = 1'b0;
        #1;
        check("req_en", 32'(m.mem_rd_en), 32'd1);
        check("req_base", m.mem_rd_addr, base);
    endtask

    // Return n words, waiting gap cycles before each; gap 0 keeps done high continuously.
    task automatic serve(input int n, input int gap);
        addr_t exp;
        for (int k = 0; k < n; k++) begin
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                #1;
                check("hold_en", 32'(m.mem_rd_en), 32'd1);
                check("hold_addr", m.mem_rd_addr, addr_q[0]);
            end
            @(negedge clk);
            #1;
            exp = addr_q.pop_front();
            check("req_en", 32'(m.mem_rd_en), 32'd1);
            check("req_addr", m.mem_rd_addr, exp);
            m.mem_rd_done = 1'b1;
            m.mem_rd_data = mem_word(exp);
            if (gap > 0 || k == n - 1) begin
                @(posedge clk);
                #1;
                m.mem_rd_done = 1'b0;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst             = 1'b1;
        f.cache_rd_en   = 1'b0;
        f.cache_rd_addr = '0;
        m.mem_rd_done   = 1'b0;
        m.mem_rd_data   = '0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_hit", 32'(f.cache_hit), 32'd0);
        check("rst_inst", f.cache_hit_inst, 32'd0);
        check("rst_en", 32'(m.mem_rd_en), 32'd0);
        check("rst_addr", m.mem_rd_addr, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Cold miss with 3-cycle gaps; hit the very next cycle after the last done.
        start_miss(32'h0000_1004);
        serve(4, 3);
        lookup(32'h0000_1004, 1'b1, mem_word(32'h0000_1004));
        check("en_drop", 32'(m.mem_rd_en), 32'd0);
        for (int k = 0; k < 4; k++)
            lookup(32'h0000_1000 + 32'(4 * k), 1'b1, mem_word(32'h0000_1000 + 32'(4 * k)));

        // Hit-under-refill on line 0x1000 while 0x1010 fills; the refilling line stays dark.
        start_miss(32'h0000_1010);
        serve(1, 2);
        lookup(32'h0000_1008, 1'b1, mem_word(32'h0000_1008));
        lookup(32'h0000_1014, 1'b0, '0);
        serve(3, 2);
        for (int k = 0; k < 4; k++)
            lookup(32'h0000_1010 + 32'(4 * k), 1'b1, mem_word(32'h0000_1010 + 32'(4 * k)));

        // Conflict eviction at index 0.
        start_miss(32'h0000_2000);
        serve(4, 1);
        lookup(32'h0000_2000, 1'b1, mem_word(32'h0000_2000));
        lookup(32'h0000_200C, 1'b1, mem_word(32'h0000_200C));
        lookup(32'h0000_1000, 1'b0, '0);
        lookup(32'h0000_1018, 1'b1, mem_word(32'h0000_1018));

        // Reset after 2 of 4 dones, then a fresh refill of 0x1010.
        start_miss(32'h0000_1020);
        serve(2, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("rst_mid_en", 32'(m.mem_rd_en), 32'd0);
        check("rst_mid_addr", m.mem_rd_addr, 32'd0);
        rst = 1'b0;
        addr_q.delete();
        lookup(32'h0000_2000, 1'b0, '0);
        start_miss(32'h0000_1010);
        serve(4, 2);
        for (int k = 0; k < 4; k++)
            lookup(32'h0000_1010 + 32'(4 * k), 1'b1, mem_word(32'h0000_1010 + 32'(4 * k)));

        // Back-to-back dones, then a stray done in IDLE must not write anything.
        start_miss(32'h0000_3048);
        serve(4, 0);
        lookup(32'h0000_3048, 1'b1, mem_word(32'h0000_3048));
        check("b2b_en_drop", 32'(m.mem_rd_en), 32'd0);
        @(negedge clk);
        m.mem_rd_done = 1'b1;
        m.mem_rd_data = 32'hDEAD_BEEF;
        @(negedge clk);
        m.mem_rd_done = 1'b0;
        #1;
        check("stray_en", 32'(m.mem_rd_en), 32'd0);
        for (int k = 0; k < 4; k++)
            lookup(32'h0000_3040 + 32'(4 * k), 1'b1, mem_word(32'h0000_3040 + 32'(4 * k)));

        // rd_en low on a valid line: no hit, zero data, no refill.
        @(negedge clk);
        f.cache_rd_en   = 1'b0;
        f.cache_rd_addr = 32'h0000_3044;
        #1;
        check("noen_hit", 32'(f.cache_hit), 32'd0);
        check("noen_inst", f.cache_hit_inst, 32'd0);
        @(negedge clk);
        #1;
        check("noen_req", 32'(m.mem_rd_en), 32'd0);
        check("sb_empty", 32'(addr_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
